hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage RV32 core.
- Generates the E-stage operand forwarding selects (forward_op1E / forward_op2E) for the forwarding muxes.
- Detects load-use hazards and branch-taken flushes.
- Sequences the multi-cycle functional unit (FU) with a start/done handshake, freezing F/D/E while the FU is busy.
- Keeps a stall-cycle performance counter.

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 50 +++++
 rtl/hazard_ctrl_fwd_sel.sv | 26 ++
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the hazard controller and the E-stage forwarding muxes.
// Holds the register address width, forward-select encodings and FU sequencer states.
// No logic; imported by every file of the hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  // Forwarding mux select encodings; 2'b11 is never produced.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file operand
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // FU_resultM / ALU result in M

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// master: pipeline/stimulus side driving register ids and stage status.
// slave : hazard_ctrl, returning forward selects, stall/flush and FU handshake.
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);

  logic [REG_W-1:0] Rs1D;
  logic [REG_W-1:0] Rs2D;
  logic [REG_W-1:0] Rs1E;
  logic [REG_W-1:0] Rs2E;
  logic [REG_W-1:0] RdE;
  logic [REG_W-1:0] RdM;
  logic [REG_W-1:0] RdW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             loadE;
  logic             PCSrcE;
  logic             mc_opE;
  logic             fu_done;
  logic [1:0]       forward_op1E;
  logic [1:0]       forward_op2E;
  logic             fu_start;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             FlushM;
  logic             fu_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, loadE, PCSrcE, mc_opE, fu_done,
    input  forward_op1E, forward_op2E, fu_start,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  fu_busy, stall_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, loadE, PCSrcE, mc_opE, fu_done,
    output forward_op1E, forward_op2E, fu_start,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output fu_busy, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-select comparator for one E-stage source operand.
// Ports: rs (source reg), rdm/rdw + regwritem/regwritew (producers in M/W), sel (mux select).
// Purely combinational; M beats W, x0 is never forwarded.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rdm,
  input  logic [REG_W-1:0] rdw,
  input  logic             regwritem,
  input  logic             regwritew,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwritem && (rdm != '0) && (rdm == rs)) begin
      sel = FWD_M;
    end else if (regwritew && (rdw != '0) && (rdw == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: operand forwarding, load-use stall, branch flush,
// multi-cycle FU start/done sequencing with F/D/E freeze, and a stall-cycle counter.
// Ports: clk, rst (sync, active-high), hz (slave bundle). Outputs are combinational from inputs+state.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic   clk,
  input  logic   rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel1;
  logic [1:0]       sel2;
  logic             lw_stall;
  logic             fu_go;
  logic             hold;
  logic             stallf;
  logic             stalld;
  logic             stalle;
  logic             flushd;
  logic             flushe;
  logic             flushm;

  hazard_ctrl_fwd_sel #(.REG_W(REG_W)) u_fwd1 (
    .rs        (hz.Rs1E),
    .rdm       (hz.RdM),
    .rdw       (hz.RdW),
    .regwritem (hz.RegWriteM),
    .regwritew (hz.RegWriteW),
    .sel       (sel1)
  );

  hazard_ctrl_fwd_sel #(.REG_W(REG_W)) u_fwd2 (
    .rs        (hz.Rs2E),
    .rdm       (hz.RdM),
    .rdw       (hz.RdW),
    .regwritem (hz.RegWriteM),
    .regwritew (hz.RegWriteW),
    .sel       (sel2)
  );

  assign lw_stall = hz.loadE && (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    state_nxt = state;
    fu_go     = 1'b0;
    hold      = 1'b0;
    stallf    = 1'b0;
    stalld    = 1'b0;
    stalle    = 1'b0;
    flushd    = 1'b0;
    flushe    = 1'b0;
    flushm    = 1'b0;
    if (!rst) begin
      // A taken branch kills the mc op in E, so it never starts the FU.
      fu_go = (state == ST_IDLE) && hz.mc_opE && !hz.PCSrcE;
      if ((state == ST_BUSY) || fu_go) begin
        // Freeze owns the pipeline: load-use and branch are deferred until E moves.
        // The done cycle releases everything so E advances into M with the FU result.
        hold   = !((state == ST_BUSY) && hz.fu_done);
        stallf = hold;
        stalld = hold;
        stalle = hold;
        flushm = hold;
      end else begin
        stallf = lw_stall;
        stalld = lw_stall;
        flushd = hz.PCSrcE;
        flushe = lw_stall || hz.PCSrcE;
      end
      if (fu_go) begin
        state_nxt = ST_BUSY;
      end else if ((state == ST_BUSY) && hz.fu_done) begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (stallf) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign hz.forward_op1E = rst ? FWD_RF : sel1;
  assign hz.forward_op2E = rst ? FWD_RF : sel2;
  assign hz.fu_start     = fu_go;
  assign hz.StallF       = stallf;
  assign hz.StallD       = stalld;
  assign hz.StallE       = stalle;
  assign hz.FlushD       = flushd;
  assign hz.FlushE       = flushe;
  assign hz.FlushM       = flushm;
  assign hz.fu_busy      = (state == ST_BUSY);
  assign hz.stall_cnt    = cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: vector table for combinational cases,
// hand-written sequences for FU sequencing, reset abort and counter wrap.
// Summary line reports check and error counts.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) hz ();
  hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  hz4 ();

  hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .hz  (hz4.slave)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww, loade, pcsrce;
    logic [1:0] f1, f2;
    logic [6:0] ctl;  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,fu_start}
  } vec_t;

  int   checks  = 0;
  int   errors  = 0;
  logic [31:0] exp_cnt = 0;
  vec_t vecs[12];

  function automatic vec_t mk(int rs1d, int rs2d, int rs1e, int rs2e, int rde, int rdm,
                              int rdw, int regwm, int regww, int loade, int pcsrce,
                              int f1, int f2, int ctl);
    vec_t v;
    v.rs1d = 5'(rs1d);  v.rs2d = 5'(rs2d);  v.rs1e = 5'(rs1e);  v.rs2e = 5'(rs2e);
    v.rde  = 5'(rde);   v.rdm  = 5'(rdm);   v.rdw  = 5'(rdw);
    v.regwm = 1'(regwm); v.regww = 1'(regww); v.loade = 1'(loade); v.pcsrce = 1'(pcsrce);
    v.f1 = 2'(f1); v.f2 = 2'(f2); v.ctl = 7'(ctl);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM, hz.fu_start};
  endfunction

  task automatic clr();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.loadE = 1'b0;
    hz.PCSrcE = 1'b0; hz.mc_opE = 1'b0; hz.fu_done = 1'b0;
  endtask

  // Called right after a negedge drive: settle, compare, then account for the coming edge.
  task automatic stepchk(input string name, input logic [6:0] ectl, input logic ebusy);
    #2;
    chk({name, "_ctl"}, 32'(ctl_now()), 32'(ectl));
    chk({name, "_busy"}, 32'(hz.fu_busy), 32'(ebusy));
    chk({name, "_cnt"}, hz.stall_cnt, exp_cnt);
    if (ectl[6]) exp_cnt = exp_cnt + 1;
  endtask

  initial begin
    hz4.Rs1D = '0; hz4.Rs2D = '0; hz4.Rs1E = '0; hz4.Rs2E = '0;
    hz4.RdE = '0; hz4.RdM = '0; hz4.RdW = '0;
    hz4.RegWriteM = 1'b0; hz4.RegWriteW = 1'b0; hz4.loadE = 1'b0;
    hz4.PCSrcE = 1'b0; hz4.mc_opE = 1'b0; hz4.fu_done = 1'b0;

    vecs[0]  = mk(0, 0, 5, 6, 0, 5, 5, 1, 1, 0, 0, 2, 0, 'b0000000);
    vecs[1]  = mk(0, 0, 0, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0, 'b0000000);
    vecs[2]  = mk(0, 0, 5, 6, 0, 0, 6, 0, 1, 0, 0, 0, 1, 'b0000000);
    vecs[3]  = mk(0, 0, 5, 6, 0, 6, 5, 1, 1, 0, 0, 1, 2, 'b0000000);
    vecs[4]  = mk(0, 0, 3, 3, 0, 3, 3, 1, 1, 0, 0, 2, 2, 'b0000000);
    vecs[5]  = mk(0, 0, 4, 4, 0, 4, 4, 0, 0, 0, 0, 0, 0, 'b0000000);
    vecs[6]  = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 'b1100100);
    vecs[7]  = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 'b1100100);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'b0000000);
    vecs[9]  = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 'b0000000);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'b0001100);
    vecs[11] = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 0, 0, 'b1101100);

    // Reset: outputs gated even with forwarding, load-use and mc op present.
    clr();
    hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.Rs1E = 5'd5;
    hz.loadE = 1'b1; hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.mc_opE = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_fwd1", 32'(hz.forward_op1E), 32'd0);
    chk("rst_ctl", 32'(ctl_now()), 32'd0);
    chk("rst_busy", 32'(hz.fu_busy), 32'd0);
    chk("rst_cnt", hz.stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clr();

    // Combinational vector table, all in IDLE.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clr();
      hz.Rs1D = vecs[i].rs1d; hz.Rs2D = vecs[i].rs2d;
      hz.Rs1E = vecs[i].rs1e; hz.Rs2E = vecs[i].rs2e;
      hz.RdE = vecs[i].rde; hz.RdM = vecs[i].rdm; hz.RdW = vecs[i].rdw;
      hz.RegWriteM = vecs[i].regwm; hz.RegWriteW = vecs[i].regww;
      hz.loadE = vecs[i].loade; hz.PCSrcE = vecs[i].pcsrce;
      #1;
      chk($sformatf("v%0d_fwd1", i), 32'(hz.forward_op1E), 32'(vecs[i].f1));
      chk($sformatf("v%0d_fwd2", i), 32'(hz.forward_op2E), 32'(vecs[i].f2));
      #(-1 + 1);
      stepchk($sformatf("v%0d", i), vecs[i].ctl, 1'b0);
    end

    // FU sequence: start, 3 busy stall cycles, done in 4th busy cycle.
    @(negedge clk); clr(); hz.mc_opE = 1'b1;
    stepchk("fu_start", 7'b1110011, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      stepchk($sformatf("fu_busy%0d", i), 7'b1110010, 1'b1);
    end
    @(negedge clk); hz.fu_done = 1'b1;
    stepchk("fu_done", 7'b0000000, 1'b1);
    @(negedge clk); clr();
    stepchk("fu_idle", 7'b0000000, 1'b0);

    // Branch and load-use during freeze are ignored; honoured once back in IDLE.
    @(negedge clk); hz.mc_opE = 1'b1;
    stepchk("br_start", 7'b1110011, 1'b0);
    @(negedge clk);
    hz.loadE = 1'b1; hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.PCSrcE = 1'b1;
    stepchk("br_busy", 7'b1110010, 1'b1);
    @(negedge clk); hz.fu_done = 1'b1;
    stepchk("br_done", 7'b0000000, 1'b1);
    @(negedge clk); hz.fu_done = 1'b0; hz.mc_opE = 1'b0;
    stepchk("br_idle", 7'b1101100, 1'b0);

    // Reset in 2nd busy cycle aborts the sequence; stray done is ignored.
    @(negedge clk); clr(); hz.mc_opE = 1'b1;
    stepchk("ra_start", 7'b1110011, 1'b0);
    @(negedge clk);
    stepchk("ra_busy1", 7'b1110010, 1'b1);
    @(negedge clk); rst = 1'b1;
    #2;
    chk("ra_rst_ctl", 32'(ctl_now()), 32'd0);
    chk("ra_rst_busy", 32'(hz.fu_busy), 32'd1);
    @(negedge clk);
    exp_cnt = 0;
    #2;
    chk("ra_after_busy", 32'(hz.fu_busy), 32'd0);
    chk("ra_after_cnt", hz.stall_cnt, 32'd0);
    rst = 1'b0; hz.mc_opE = 1'b0; hz.fu_done = 1'b1;
    stepchk("ra_stray", 7'b0000000, 1'b0);
    @(negedge clk); hz.fu_done = 1'b0;
    stepchk("ra_idle", 7'b0000000, 1'b0);

    // 4-bit counter wraps 15 -> 0 -> 1 under a held load-use stall.
    @(negedge clk);
    hz4.loadE = 1'b1; hz4.RdE = 5'd7; hz4.Rs1D = 5'd7;
    for (int k = 0; k < 18; k++) begin
      #2;
      chk($sformatf("wrap%0d", k), 32'(hz4.stall_cnt), 32'(k % 16));
      @(negedge clk);
    end
    hz4.loadE = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
